// File: rtl/bsg_fsb_hop_out_rr_arbiter.sv
// bsg_fsb_hop_out_rr_arbiter: round-robin packet-locking arbiter onto a credit-flow-controlled, registered hop-out link
module bsg_fsb_hop_out_rr_arbiter #(
  parameter int els_p     = 4,
  parameter int width_p   = 16,
  parameter int credits_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         last_i,
  output logic [els_p-1:0]         yumi_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     last_o,
  input  logic                     credit_i,
  output logic                     credit_overflow_o
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(credits_p + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [ptr_w-1:0] rr_ptr, rr_ptr_n, owner, owner_n, rr_gnt, sel;
  logic [cnt_w-1:0] cnt, cnt_n;
  logic [width_p-1:0] sel_data;
  logic go, sel_last, ovf_n;
  always_comb begin
    logic [ptr_w-1:0] idx;
    idx = '0;
    rr_gnt = rr_ptr;
    for (int k = els_p - 1; k >= 0; k--) begin
      idx = ptr_w'((int'(rr_ptr) + k) % els_p);
      rr_gnt = v_i[idx] ? idx : rr_gnt;
    end
  end
  // when nobody requests, rr_gnt points at an idle requester, so v_i[sel] gates the grant in both states
  always_comb begin
    sel = (state == LOCKED) ? owner : rr_gnt;
    go = reset_n_i && (cnt != '0) && v_i[sel];
    sel_last = last_i[sel];
    sel_data = data_i[int'(sel)*width_p +: width_p];
    yumi_o = go ? (els_p'(1) << sel) : '0;
    state_n = !go ? state : (sel_last ? IDLE : LOCKED);
    owner_n = (go && !sel_last) ? sel : owner;
    rr_ptr_n = !(go && sel_last) ? rr_ptr : ((sel == ptr_w'(els_p - 1)) ? '0 : sel + 1'b1);
    cnt_n = (go && !credit_i) ? cnt - 1'b1 :
            (credit_i && !go && cnt != cnt_w'(credits_p)) ? cnt + 1'b1 : cnt;
    ovf_n = credit_overflow_o | (credit_i && !go && cnt == cnt_w'(credits_p));
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= cnt_w'(credits_p);
      credit_overflow_o <= 1'b0;
      v_o <= 1'b0;
      data_o <= '0;
      last_o <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      owner <= owner_n;
      cnt <= cnt_n;
      credit_overflow_o <= ovf_n;
      v_o <= go;
      data_o <= go ? sel_data : data_o;
      last_o <= go ? sel_last : last_o;
    end
endmodule

// File: tb/tb_bsg_fsb_hop_out_rr_arbiter.sv
// tb_bsg_fsb_hop_out_rr_arbiter: directed stimulus checked against a per-cycle behavioural model plus literal expectations
module tb_bsg_fsb_hop_out_rr_arbiter;
  localparam int N = 4, W = 16, CR = 4;
  logic clk_i = 1'b0, reset_n_i = 1'b0, credit_i = 1'b0;
  logic [N-1:0] v_i = '0, last_i = '0, yumi_o;
  logic [N*W-1:0] data_i;
  logic [W-1:0] d [N] = '{default: '0};
  logic v_o, last_o, credit_overflow_o;
  logic [W-1:0] data_o;
  int n_vec = 0, n_bad = 0;

  bsg_fsb_hop_out_rr_arbiter #(.els_p(N), .width_p(W), .credits_p(CR)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
    .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .last_o(last_o),
    .credit_i(credit_i), .credit_overflow_o(credit_overflow_o)
  );

  always #5 clk_i = ~clk_i;
  always_comb for (int i = 0; i < N; i++) data_i[i*W +: W] = d[i];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: owner -1 means no packet in progress
  int m_owner = -1, m_rr = 0, m_cred = CR;
  logic m_v = 0, m_last = 0, m_ovf = 0;
  logic [W-1:0] m_data = '0;
  int p_owner, p_rr, p_cred, g;
  logic p_v, p_last, p_ovf;
  logic [W-1:0] p_data;

  function automatic int exp_grant();
    if (!reset_n_i || m_cred == 0) return -1;
    if (m_owner >= 0) return 1'(v_i >> m_owner) ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (1'(v_i >> ((m_rr + k) % N))) return (m_rr + k) % N;
    return -1;
  endfunction

  always @(negedge clk_i) begin
    g = exp_grant();
    chk("yumi", 32'(yumi_o), (g >= 0) ? 32'(N'(1) << g) : 32'd0);
    chk("v_o", 32'(v_o), 32'(m_v));
    chk("data_o", 32'(data_o), 32'(m_data));
    chk("last_o", 32'(last_o), 32'(m_last));
    chk("overflow", 32'(credit_overflow_o), 32'(m_ovf));
    p_v = (g >= 0);
    p_data = p_v ? W'(data_i >> (g * W)) : m_data;
    p_last = p_v ? 1'(last_i >> g) : m_last;
    p_owner = m_owner;
    p_rr = m_rr;
    if (p_v) begin
      if (p_last) begin p_owner = -1; p_rr = (g + 1) % N; end
      else p_owner = g;
    end
    p_cred = m_cred - (p_v ? 1 : 0) + (credit_i ? 1 : 0);
    p_ovf = m_ovf || (p_cred > CR);
    if (p_cred > CR) p_cred = CR;
  end

  always @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      m_owner = -1; m_rr = 0; m_cred = CR; m_v = 0; m_last = 0; m_ovf = 0; m_data = '0;
    end else begin
      m_owner = p_owner; m_rr = p_rr; m_cred = p_cred; m_v = p_v;
      m_last = p_last; m_ovf = p_ovf; m_data = p_data;
    end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    cyc(); cyc();
    #1;
    chk("rst_v_o", 32'(v_o), 0); chk("rst_data_o", 32'(data_o), 0);
    chk("rst_last_o", 32'(last_o), 0); chk("rst_ovf", 32'(credit_overflow_o), 0);
    reset_n_i = 1;
    // round robin across four single-flit requesters
    cyc();
    v_i = 4'b1111; last_i = 4'b1111; credit_i = 1;
    for (int i = 0; i < N; i++) d[i] = 16'hA000 + 16'(i);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t1_yumi", 32'(yumi_o), 32'(4'b0001 << (k % 4)));
      chk("t1_v_o", 32'(v_o), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) chk("t1_data", 32'(data_o), 32'h0000A000 + 32'((k - 1) % 4));
      cyc();
    end
    v_i = 0; last_i = 0; credit_i = 0;
    #1 chk("t1_tail", 32'(data_o), 32'hA000);
    // requester 2 locks for a 3-flit packet while requester 0 waits
    cyc(); v_i = 4'b0101; last_i = 4'b0001; d[2] = 16'hB001; d[0] = 16'hC000; credit_i = 1;
    #1 chk("t2_yumi0", 32'(yumi_o), 32'b0100);
    cyc(); d[2] = 16'hB002;
    #1 chk("t2_yumi1", 32'(yumi_o), 32'b0100); chk("t2_d1", 32'(data_o), 32'hB001); chk("t2_l1", 32'(last_o), 0);
    cyc(); d[2] = 16'hB003; last_i = 4'b0101;
    #1 chk("t2_yumi2", 32'(yumi_o), 32'b0100); chk("t2_d2", 32'(data_o), 32'hB002); chk("t2_l2", 32'(last_o), 0);
    cyc(); v_i = 4'b0001;
    #1 chk("t2_yumi3", 32'(yumi_o), 32'b0001); chk("t2_d3", 32'(data_o), 32'hB003); chk("t2_l3", 32'(last_o), 1);
    cyc(); v_i = 0; credit_i = 0;
    #1 chk("t2_yumi4", 32'(yumi_o), 0); chk("t2_d4", 32'(data_o), 32'hC000);
    // credit exhaustion
    for (int k = 0; k < 6; k++) begin
      cyc(); v_i = 4'b0010; last_i = 4'b0010; d[1] = 16'hD000 + 16'(k);
      #1 chk("t3_yumi", 32'(yumi_o), (k < 4) ? 32'b0010 : 32'd0);
    end
    cyc(); credit_i = 1;
    #1 chk("t3_credit_cycle", 32'(yumi_o), 0);
    cyc(); credit_i = 0;
    #1 chk("t3_one_more", 32'(yumi_o), 32'b0010);
    cyc();
    #1 chk("t3_blocked", 32'(yumi_o), 0);
    // simultaneous send and credit at count 1, then overflow
    cyc(); v_i = 0; credit_i = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(); v_i = 4'b0010; last_i = 4'b0010; credit_i = 1;
      #1 chk("t4_stream", 32'(yumi_o), 32'b0010);
    end
    cyc(); credit_i = 0;
    #1 chk("t4_last_credit", 32'(yumi_o), 32'b0010);
    cyc();
    #1 chk("t4_empty", 32'(yumi_o), 0);
    cyc(); v_i = 0; credit_i = 1;
    for (int k = 0; k < 3; k++) begin cyc(); #1 chk("t4_no_ovf", 32'(credit_overflow_o), 0); end
    cyc();
    #1 chk("t4_full_no_ovf", 32'(credit_overflow_o), 0);
    cyc(); credit_i = 0;
    #1 chk("t4_ovf_set", 32'(credit_overflow_o), 1);
    cyc();
    #1 chk("t4_ovf_sticky", 32'(credit_overflow_o), 1);
    // asynchronous reset in the middle of a packet
    cyc(); v_i = 4'b1000; last_i = 0; d[3] = 16'hE001;
    #1 chk("t5_yumi0", 32'(yumi_o), 32'b1000);
    cyc(); d[3] = 16'hE002;
    #1 chk("t5_yumi1", 32'(yumi_o), 32'b1000); chk("t5_d1", 32'(data_o), 32'hE001);
    cyc(); d[3] = 16'hE003; v_i = 4'b1001; d[0] = 16'hF000; last_i = 4'b0001;
    #1 chk("t5_locked", 32'(yumi_o), 32'b1000); chk("t5_v_pre", 32'(v_o), 1);
    #1 reset_n_i = 0;
    #1 chk("t5_rst_yumi", 32'(yumi_o), 0); chk("t5_rst_v", 32'(v_o), 0);
    chk("t5_rst_ovf", 32'(credit_overflow_o), 0); chk("t5_rst_data", 32'(data_o), 0);
    cyc();
    #1 chk("t5_held", 32'(yumi_o), 0);
    reset_n_i = 1; last_i = 4'b1001;
    #1 chk("t5_first", 32'(yumi_o), 32'b0001);
    cyc();
    #1 chk("t5_second", 32'(yumi_o), 32'b1000); chk("t5_d0", 32'(data_o), 32'hF000);
    cyc(); v_i = 0;
    #1 chk("t5_d3", 32'(data_o), 32'hE003); chk("t5_l3", 32'(last_o), 1);
    // owner bubble
    cyc(); credit_i = 1;
    cyc();
    cyc(); credit_i = 0; v_i = 4'b0010; last_i = 0; d[1] = 16'h1111;
    #1 chk("t6_lock", 32'(yumi_o), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      cyc(); v_i = 4'b0100; last_i = 4'b0100; d[2] = 16'h2222;
      #1 chk("t6_bubble", 32'(yumi_o), 0);
    end
    cyc(); v_i = 4'b0110; last_i = 4'b0110; d[1] = 16'h1112;
    #1 chk("t6_resume", 32'(yumi_o), 32'b0010);
    cyc(); v_i = 4'b0100;
    #1 chk("t6_next", 32'(yumi_o), 32'b0100); chk("t6_d", 32'(data_o), 32'h1112); chk("t6_l", 32'(last_o), 1);
    cyc(); v_i = 0;
    #1 chk("t6_done", 32'(yumi_o), 0); chk("t6_d2", 32'(data_o), 32'h2222);
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
